nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencing controller that time-shares the team's single 4-bit ripple adder (fa4) to add or subtract two wide operands one nibble per clock, least-significant nibble first. It holds the inter-nibble carry in a flop, presents operands through a valid/ready handshake, and returns a registered wide result. It sits in top between the pushbutton/operand capture logic and the seven-segment/LED display path, driving the fa4 instance's A/B/Cin and consuming its S/Cout.

## Interface
- NIBBLES, 4: operand width in nibbles (legal 2–8); word width W = 4*NIBBLES
- hz100  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  request: operands valid this cycle
- start_ready  out  1  controller can accept a request
- op_sub  in  1  1 = A−B, 0 = A+B (sampled with start; ignored without NSA_SUB_EN)
- op_a  in  W  operand A
- op_b  in  W  operand B
- abort  in  1  cancel an in-progress operation
- add_a  out  4  nibble to fa4 A
- add_b  out  4  nibble to fa4 B
- add_cin  out  1  carry to fa4 Cin
- add_s  in  4  fa4 sum
- add_cout  in  1  fa4 carry out
- busy  out  1  high in RUN
- res_valid  out  1  result and carry valid
- res_ready  in  1  consumer takes result
- result  out  W  registered sum/difference
- carry  out  1  final carry (subtract: 1 = no borrow)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start_ready=1. On start=1 latch op_a, op_b, op_sub; idx←0; carry flop←op_sub (0 for add); result←0; go RUN.
- RUN: add_a=a_reg[4*idx+:4]; add_b=b_reg nibble (bitwise inverted when op_sub); add_cin=carry flop. Each edge: result nibble idx←add_s; carry flop←add_cout; idx←idx+1. On edge with idx=NIBBLES−1 go DONE.
- DONE: res_valid=1, result/carry stable. res_ready=1 → IDLE.
- abort=1 in RUN → IDLE next edge, res_valid never asserts, result keeps partial value. abort in IDLE/DONE ignored. abort and final RUN edge together: abort wins.
- start outside IDLE ignored (start_ready=0); no queuing.
- Outside RUN add_a, add_b, add_cin drive 0.
- Wrap-around: result is modulo 2^W; overflow beyond W reported only via carry.
- idx width = clog2(NIBBLES), never exceeds NIBBLES−1.

## Timing
- Reset values (any time reset=0, including mid-RUN): state IDLE, start_ready=1, busy=0, res_valid=0, result=0, carry=0, add_a/add_b/add_cin=0, idx=0.
- Accepting edge = edge where state=IDLE and start=1.
- fa4 is combinational; adder path add_a/b/cin→add_s/cout must settle within one cycle.
- res_valid rises exactly NIBBLES edges after accepting edge; busy high for exactly NIBBLES cycles.
- Result handoff on edge with res_valid & res_ready; start_ready high in the following cycle; minimum request-to-request spacing NIBBLES+2 cycles.
- res_ready held low: DONE persists indefinitely, outputs unchanged.

## Configuration
- NSA_SUB_EN defined: op_sub honoured (B nibbles inverted, initial carry 1, two's-complement difference).
- NSA_SUB_EN undefined: op_sub ignored, every operation is addition with initial carry 0; no inversion logic synthesised.

## Test plan
- NIBBLES=4, add 0x1234+0x0FCD → after 4 busy cycles res_valid=1, result=0x2201, carry=0; add_a sequence 4,3,2,1.
- Add 0xFFFF+0x0001 → result=0x0000, carry=1; add_cin sequence 0,1,1,1.
- NSA_SUB_EN: 0x0005−0x0007 → result=0xFFFE, carry=0; 0x0007−0x0005 → 0x0002, carry=1. Without macro same stimulus with op_sub=1 → 0x000C, carry=0.
- Backpressure: hold res_ready=0 for 10 cycles → res_valid, result stable, start pulses ignored; res_ready=1 → IDLE, start_ready=1 next cycle.
- abort on 2nd RUN cycle → IDLE next edge, res_valid stays 0; abort coincident with final RUN edge → no res_valid.
- reset=0 on 3rd RUN cycle (asynchronous, mid-cycle) → all outputs at reset values immediately; after release a fresh 0x0001+0x0001 yields 0x0002.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake, operand, result and fa4 adder bus between the requester/adder side (master) and the serial add controller (slave).
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         start_ready;
    logic         op_sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         abort;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         carry;

    modport master (
        output start, op_sub, op_a, op_b, abort, res_ready, add_s, add_cout,
        input  start_ready, add_a, add_b, add_cin, busy, res_valid, result, carry
    );

    modport slave (
        input  start, op_sub, op_a, op_b, abort, res_ready, add_s, add_cout,
        output start_ready, add_a, add_b, add_cin, busy, res_valid, result, carry
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial add/subtract through one external 4-bit adder, LS nibble first; result valid NIBBLES cycles after accept.
// Result held in DONE until res_ready; subtraction only when NSA_SUB_EN is defined.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                      hz100,
    input  logic                      reset,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_q, b_q, result_q;
    logic [IW-1:0] idx;
    logic          carry_q;
    logic          accept, step, init_carry;
    logic [3:0]    a_nib, b_nib;
    int            nib_base;

    assign accept   = (state == IDLE) && bus.start;
    assign step     = (state == RUN) && !bus.abort;
    assign nib_base = 4 * int'(idx);
    assign a_nib    = a_q[nib_base +: 4];

`ifdef NSA_SUB_EN
    logic sub_q;

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset)      sub_q <= 1'b0;
        else if (accept) sub_q <= bus.op_sub;
    end

    assign init_carry = bus.op_sub;
    assign b_nib      = sub_q ? ~b_q[nib_base +: 4] : b_q[nib_base +: 4];
`else
    logic unused_op_sub;

    assign unused_op_sub = bus.op_sub;
    assign init_carry    = 1'b0;
    assign b_nib         = b_q[nib_base +: 4];
`endif

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN: begin
                // abort beats completion on the final nibble
                if (bus.abort)        state_nxt = IDLE;
                else if (idx == LAST) state_nxt = DONE;
            end
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.start_ready = 1'b0;
        bus.busy        = 1'b0;
        bus.res_valid   = 1'b0;
        bus.add_a       = 4'h0;
        bus.add_b       = 4'h0;
        bus.add_cin     = 1'b0;
        case (state)
            IDLE: bus.start_ready = 1'b1;
            RUN: begin
                bus.busy    = 1'b1;
                bus.add_a   = a_nib;
                bus.add_b   = b_nib;
                bus.add_cin = carry_q;
            end
            DONE:    bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            idx      <= '0;
        end else if (accept) begin
            a_q      <= bus.op_a;
            b_q      <= bus.op_b;
            result_q <= '0;
            carry_q  <= init_carry;
            idx      <= '0;
        end else if (step) begin
            result_q[nib_base +: 4] <= bus.add_s;
            carry_q                 <= bus.add_cout;
            idx                     <= (idx == LAST) ? '0 : idx + 1'b1;
        end else if (state == RUN) begin
            idx <= '0;
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomised and directed bench for nibble_serial_adder_ctrl with a behavioural fa4 and arithmetic reference model.
module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic hz100 = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 hz100 = ~hz100;

    nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();

    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .hz100 (hz100),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic eff_sub(input logic s);
`ifdef NSA_SUB_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    // {carry, result} from plain arithmetic: a+b, or a-b offset by 2^W (carry = no borrow)
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint unsigned r;
        if (eff_sub(s)) r = longint'(a) + (longint'(1) << W) - longint'(b);
        else            r = longint'(a) + longint'(b);
        return r[W:0];
    endfunction

    function automatic logic [3:0] exp_bnib(input logic [W-1:0] b, input logic s, input int k);
        logic [W-1:0] beff;
        beff = eff_sub(s) ? ~b : b;
        return beff[4*k +: 4];
    endfunction

    function automatic logic exp_cin(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int k);
        longint unsigned m, beff, p;
        m    = (longint'(1) << (4 * k)) - 1;
        beff = eff_sub(s) ? longint'(~b) : longint'(b);
        p    = (longint'(a) & m) + (beff & m) + longint'(eff_sub(s));
        return p[4*k];
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_start_ready"}, 32'(bus.start_ready), 32'd1);
        chk({tag, "_busy"},        32'(bus.busy),        32'd0);
        chk({tag, "_res_valid"},   32'(bus.res_valid),   32'd0);
        chk({tag, "_add_a"},       32'(bus.add_a),       32'd0);
        chk({tag, "_add_b"},       32'(bus.add_b),       32'd0);
        chk({tag, "_add_cin"},     32'(bus.add_cin),     32'd0);
    endtask

    // called at a negedge with the controller idle; returns at the negedge of RUN cycle 0
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        chk("accept_start_ready", 32'(bus.start_ready), 32'd1);
        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.op_sub = s;
        @(negedge hz100);
        bus.start = 1'b0;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
    endtask

    task automatic run_cycles(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int n);
        for (int k = 0; k < n; k++) begin
            chk("run_busy",      32'(bus.busy),      32'd1);
            chk("run_res_valid", 32'(bus.res_valid), 32'd0);
            chk("run_add_a",     32'(bus.add_a),     32'(a[4*k +: 4]));
            chk("run_add_b",     32'(bus.add_b),     32'(exp_bnib(b, s, k)));
            chk("run_add_cin",   32'(bus.add_cin),   32'(exp_cin(a, b, s, k)));
            @(negedge hz100);
        end
    endtask

    task automatic done_checks(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] e;
        e = model(a, b, s);
        chk("done_res_valid",   32'(bus.res_valid),   32'd1);
        chk("done_busy",        32'(bus.busy),        32'd0);
        chk("done_start_ready", 32'(bus.start_ready), 32'd0);
        chk("done_result",      32'(bus.result),      32'(e[W-1:0]));
        chk("done_carry",       32'(bus.carry),       32'(e[W]));
    endtask

    task automatic release_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] e;
        e = model(a, b, s);
        bus.res_ready = 1'b1;
        @(negedge hz100);
        bus.res_ready = 1'b0;
        idle_checks("after_release");
        chk("after_release_result", 32'(bus.result), 32'(e[W-1:0]));
    endtask

    task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        start_op(a, b, s);
        run_cycles(a, b, s, N);
        done_checks(a, b, s);
        release_result(a, b, s);
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        logic [W:0]   e;

        bus.start = 1'b0; bus.op_sub = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.abort = 1'b0; bus.res_ready = 1'b0;

        repeat (2) @(negedge hz100);
        idle_checks("reset");
        chk("reset_result", 32'(bus.result), 32'd0);
        chk("reset_carry",  32'(bus.carry),  32'd0);
        reset = 1'b1;
        @(negedge hz100);

        full_op(16'h1234, 16'h0FCD, 1'b0);
        full_op(16'hFFFF, 16'h0001, 1'b0);
        full_op(16'h0005, 16'h0007, 1'b1);
        full_op(16'h0007, 16'h0005, 1'b1);
        full_op(16'h0000, 16'h0000, 1'b1);

        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom_range(1));
            full_op(a, b, s);
        end

        // abort is ignored while idle
        bus.abort = 1'b1;
        @(negedge hz100);
        bus.abort = 1'b0;
        idle_checks("abort_idle");

        // backpressure: DONE holds, start ignored
        a = 16'hBEEF; b = 16'h1111;
        start_op(a, b, 1'b0);
        run_cycles(a, b, 1'b0, N);
        for (int i = 0; i < 10; i++) begin
            bus.start = i[0];
            bus.abort = i[1];
            done_checks(a, b, 1'b0);
            @(negedge hz100);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        done_checks(a, b, 1'b0);
        release_result(a, b, 1'b0);

        // abort on second RUN cycle keeps only nibble 0
        a = 16'h3579; b = 16'h2468;
        e = model(a, b, 1'b0);
        start_op(a, b, 1'b0);
        run_cycles(a, b, 1'b0, 1);
        bus.abort = 1'b1;
        @(negedge hz100);
        bus.abort = 1'b0;
        idle_checks("abort2");
        chk("abort2_result", 32'(bus.result), 32'(e[3:0]));

        // abort on final RUN edge suppresses completion
        a = 16'h9ABC; b = 16'h7654;
        e = model(a, b, 1'b0);
        start_op(a, b, 1'b0);
        run_cycles(a, b, 1'b0, N - 1);
        bus.abort = 1'b1;
        @(negedge hz100);
        bus.abort = 1'b0;
        idle_checks("abort_last");
        chk("abort_last_result", 32'(bus.result), 32'(e[11:0]));
        for (int i = 0; i < 3; i++) begin
            @(negedge hz100);
            chk("abort_last_no_valid", 32'(bus.res_valid), 32'd0);
        end

        // asynchronous reset mid-cycle in the third RUN cycle
        a = 16'hFFFF; b = 16'hFFFF;
        start_op(a, b, 1'b0);
        run_cycles(a, b, 1'b0, 2);
        #2 reset = 1'b0;
        #1;
        idle_checks("mid_reset");
        chk("mid_reset_result", 32'(bus.result), 32'd0);
        chk("mid_reset_carry",  32'(bus.carry),  32'd0);
        @(negedge hz100);
        reset = 1'b1;
        @(negedge hz100);
        full_op(16'h0001, 16'h0001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
